alarm_entry_ctrl: RTL and testbench

Keypad entry sequencer that sits in front of `alarm_reg` and the time-load path of the digital alarm clock. It collects four BCD digits in HH:MM order and validates each digit against 24-hour limits as it arrives. On the fourth valid digit it issues a one-cycle load strobe to either the alarm register or the current-time counter. It owns entry mode, digit position, digit validation and an inactivity timeout.

---
 rtl/alarm_clock_pkg.sv | 39 +++
 rtl/alarm_entry_ctrl_timer.sv | 32 +++
 rtl/alarm_entry_ctrl.sv | 143 ++++++++++++++
 tb/tb_alarm_entry_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared types and digit limits for the alarm clock keypad entry path
//
// Contents:
//   entry_state_t  : entry sequencer states (IDLE, ENTRY, COMMIT)
//   MAX_*          : per-position BCD limits for 24-hour HH:MM entry
//   MODE_ALARM/TIME: entry target selection
//   digit_limit()  : largest legal digit for a position, given the stored ms_hr
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } entry_state_t;

    localparam logic [3:0] MAX_MS_HR    = 4'd2;
    localparam logic [3:0] MAX_LS_HR    = 4'd9;
    localparam logic [3:0] MAX_LS_HR_20 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN   = 4'd5;
    localparam logic [3:0] MAX_LS_MIN   = 4'd9;

    localparam logic MODE_ALARM = 1'b1;
    localparam logic MODE_TIME  = 1'b0;

    // Hours 20-23 restrict the units-of-hour digit to 0-3.
    function automatic logic [3:0] digit_limit(input logic [1:0] pos, input logic [3:0] ms_hr);
        logic [3:0] lim;
        lim = MAX_LS_MIN;
        case (pos)
            2'd0: lim = MAX_MS_HR;
            2'd1: lim = (ms_hr == MAX_MS_HR) ? MAX_LS_HR_20 : MAX_LS_HR;
            2'd2: lim = MAX_MS_MIN;
            2'd3: lim = MAX_LS_MIN;
            default: lim = MAX_LS_MIN;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/alarm_entry_ctrl_timer.sv
// rtl/alarm_entry_ctrl_timer.sv - clearable inactivity up-counter with terminal-count flag
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous active-low reset
//   enable : count while high, hold otherwise
//   clear  : synchronous clear to 0 (overrides enable)
//   tc     : high while enabled and the count sits at TIMEOUT_CYCLES-1
module entry_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = enable && (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alarm_entry_ctrl.sv
// rtl/alarm_entry_ctrl.sv - keypad HH:MM entry sequencer feeding alarm_reg and the time-load path
//
// Ports:
//   clock, reset            : system clock; synchronous active-low reset
//   key[3:0], key_valid     : keypad digit and its one-cycle qualifier
//   alarm_button            : strobe, start (or restart) alarm entry
//   time_button             : strobe, start (or restart) time entry
//   new_ms_hr..new_ls_min   : entry buffer, stable in IDLE for the load target
//   load_new_alarm          : one-cycle load strobe to alarm_reg
//   load_new_time           : one-cycle load strobe to the time counter
//   entry_active            : high from entry start through the COMMIT cycle
//   entry_mode              : 1 = alarm, 0 = time
//   entry_error             : one-cycle pulse on a rejected digit
//   entry_timeout           : one-cycle pulse when an idle entry is abandoned
module alarm_entry_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       entry_active,
    output logic       entry_mode,
    output logic       entry_error,
    output logic       entry_timeout
);

    entry_state_t state;
    logic [1:0]   pos;
    logic         button;
    logic         sel_mode;
    logic         digit_ok;
    logic         in_entry;
    logic         timer_clear;
    logic         timer_tc;

    assign button   = alarm_button | time_button;
    assign sel_mode = alarm_button ? MODE_ALARM : MODE_TIME;
    assign in_entry = (state == ST_ENTRY);
    // Limits are all <= 9, so codes 10-15 fail this compare without a separate check.
    assign digit_ok = (key <= digit_limit(pos, new_ms_hr));

    // Any keypress (even a rejected one) counts as activity; leaving ENTRY
    // for any reason also parks the counter at zero.
    assign timer_clear = !in_entry || button || key_valid || timer_tc;

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (in_entry),
        .clear  (timer_clear),
        .tc     (timer_tc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            pos            <= 2'd0;
            entry_mode     <= MODE_TIME;
            new_ms_hr      <= 4'd0;
            new_ls_hr      <= 4'd0;
            new_ms_min     <= 4'd0;
            new_ls_min     <= 4'd0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_active   <= 1'b0;
            entry_error    <= 1'b0;
            entry_timeout  <= 1'b0;
        end else begin
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_error    <= 1'b0;
            entry_timeout  <= 1'b0;

            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (button) begin
                        // Start or restart; a key on the same edge is dropped.
                        state        <= ST_ENTRY;
                        entry_active <= 1'b1;
                        entry_mode   <= sel_mode;
                        pos          <= 2'd0;
                        new_ms_hr    <= 4'd0;
                        new_ls_hr    <= 4'd0;
                        new_ms_min   <= 4'd0;
                        new_ls_min   <= 4'd0;
                    end else if (in_entry && key_valid) begin
                        if (digit_ok) begin
                            case (pos)
                                2'd0: new_ms_hr  <= key;
                                2'd1: new_ls_hr  <= key;
                                2'd2: new_ms_min <= key;
                                default: new_ls_min <= key;
                            endcase
                            // Position wraps to 0 after the last digit.
                            pos <= pos + 2'd1;
                            if (pos == 2'd3) begin
                                state <= ST_COMMIT;
                            end
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end else if (in_entry && timer_tc) begin
                        state         <= ST_IDLE;
                        entry_active  <= 1'b0;
                        entry_timeout <= 1'b1;
                        pos           <= 2'd0;
                    end
                end

                ST_COMMIT: begin
                    if (entry_mode == MODE_ALARM) begin
                        load_new_alarm <= 1'b1;
                    end else begin
                        load_new_time <= 1'b1;
                    end
                    state        <= ST_IDLE;
                    entry_active <= 1'b0;
                end

                default: begin
                    state        <= ST_IDLE;
                    entry_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// tb/tb_alarm_entry_ctrl.sv - self-checking bench for alarm_entry_ctrl
module tb_alarm_entry_ctrl;

    localparam int TO = 16;

    typedef struct packed {
        logic       mode;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
    logic       load_new_alarm, load_new_time;
    logic       entry_active, entry_mode, entry_error, entry_timeout;

    int   tests = 0;
    int   fails = 0;
    int   loads_seen = 0;
    int   loads_pushed = 0;
    exp_t sb[$];

    alarm_entry_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .key            (key),
        .key_valid      (key_valid),
        .alarm_button   (alarm_button),
        .time_button    (time_button),
        .new_ms_hr      (new_ms_hr),
        .new_ls_hr      (new_ls_hr),
        .new_ms_min     (new_ms_min),
        .new_ls_min     (new_ls_min),
        .load_new_alarm (load_new_alarm),
        .load_new_time  (load_new_time),
        .entry_active   (entry_active),
        .entry_mode     (entry_mode),
        .entry_error    (entry_error),
        .entry_timeout  (entry_timeout)
    );

    always #5 clock = ~clock;

    // Scoreboard consumer: every load strobe must match the oldest pushed entry.
    always @(negedge clock) begin
        if (reset && (load_new_alarm || load_new_time)) begin
            exp_t e;
            loads_seen++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_load: alarm=%0b time=%0b, required no load", load_new_alarm, load_new_time);
            end else begin
                e = sb.pop_front();
                if ({load_new_alarm, load_new_time, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min}
                    !== {e.mode, ~e.mode, e.d0, e.d1, e.d2, e.d3}) begin
                    fails++;
                    $display("FAIL sb_load: got a=%0b t=%0b %0d%0d:%0d%0d, required a=%0b t=%0b %0d%0d:%0d%0d",
                             load_new_alarm, load_new_time, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
                             e.mode, ~e.mode, e.d0, e.d1, e.d2, e.d3);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic a, input logic t);
        alarm_button = a;
        time_button  = t;
        step();
        alarm_button = 1'b0;
        time_button  = 1'b0;
    endtask

    task automatic key_in(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic push(input logic m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        sb.push_back('{mode: m, d0: a, d1: b, d2: c, d3: d});
        loads_pushed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        tests++;
        if ({new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, load_new_alarm, load_new_time,
             entry_active, entry_mode, entry_error, entry_timeout} !== 22'd0) begin
            fails++;
            $display("FAIL reset_state: got %h, required 0", {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
                     load_new_alarm, load_new_time, entry_active, entry_mode, entry_error, entry_timeout});
        end
        reset = 1'b1;
        // key_valid in IDLE must be ignored
        key_in(4'd1);
        tests++;
        if ({entry_active, new_ms_hr, entry_error} !== 6'd0) begin
            fails++;
            $display("FAIL idle_key_ignored: active=%0b ms_hr=%0d err=%0b, required 0/0/0", entry_active, new_ms_hr, entry_error);
        end
    endtask

    task automatic test_alarm_0645();
        press(1'b1, 1'b0);
        tests++;
        if ({entry_active, entry_mode} !== 2'b11) begin
            fails++;
            $display("FAIL alarm_start: active=%0b mode=%0b, required 1/1", entry_active, entry_mode);
        end
        key_in(4'd0);
        key_in(4'd6);
        tests++;
        if (new_ls_hr !== 4'd6) begin
            fails++;
            $display("FAIL alarm_ls_hr_visible: got %0d, required 6", new_ls_hr);
        end
        key_in(4'd4);
        push(1'b1, 4'd0, 4'd6, 4'd4, 4'd5);
        key_in(4'd5);
        tests++;
        if ({entry_active, load_new_alarm, load_new_time} !== 3'b100) begin
            fails++;
            $display("FAIL alarm_commit_cycle: active/la/lt=%b, required 100", {entry_active, load_new_alarm, load_new_time});
        end
        step();
        tests++;
        if ({load_new_alarm, load_new_time, entry_active, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min}
            !== {3'b100, 16'h0645}) begin
            fails++;
            $display("FAIL alarm_load: la=%0b lt=%0b act=%0b buf=%h, required 1/0/0 0645",
                     load_new_alarm, load_new_time, entry_active, {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
        end
        step();
        tests++;
        if (load_new_alarm !== 1'b0) begin
            fails++;
            $display("FAIL alarm_load_width: la=%0b, required 0", load_new_alarm);
        end
    endtask

    task automatic test_time_2359();
        bit mode_bad = 0;
        press(1'b0, 1'b1);
        mode_bad |= (entry_mode !== 1'b0);
        key_in(4'd2); mode_bad |= (entry_mode !== 1'b0);
        key_in(4'd3); mode_bad |= (entry_mode !== 1'b0);
        key_in(4'd5); mode_bad |= (entry_mode !== 1'b0);
        push(1'b0, 4'd2, 4'd3, 4'd5, 4'd9);
        key_in(4'd9); mode_bad |= (entry_mode !== 1'b0);
        tests++;
        if (mode_bad) begin
            fails++;
            $display("FAIL time_mode: entry_mode not 0 during time entry, last=%0b, required 0", entry_mode);
        end
        step();
        tests++;
        if ({load_new_time, load_new_alarm} !== 2'b10) begin
            fails++;
            $display("FAIL time_load: lt=%0b la=%0b, required 1/0", load_new_time, load_new_alarm);
        end
        step();
    endtask

    task automatic test_invalid();
        press(1'b1, 1'b0);
        key_in(4'd2);
        key_in(4'd4);
        tests++;
        if ({entry_error, new_ls_hr} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL invalid_ls_hr: err=%0b ls_hr=%0d, required 1/0", entry_error, new_ls_hr);
        end
        step();
        tests++;
        if (entry_error !== 1'b0) begin
            fails++;
            $display("FAIL error_width: err=%0b, required 0", entry_error);
        end
        key_in(4'd3);
        tests++;
        if ({entry_error, new_ls_hr} !== {1'b0, 4'd3}) begin
            fails++;
            $display("FAIL pos_held: err=%0b ls_hr=%0d, required 0/3", entry_error, new_ls_hr);
        end
        key_in(4'd6);
        tests++;
        if ({entry_error, new_ms_min} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL invalid_ms_min: err=%0b ms_min=%0d, required 1/0", entry_error, new_ms_min);
        end
        key_in(4'd0);
        key_in(4'd12);
        tests++;
        if ({entry_error, entry_active} !== 2'b11) begin
            fails++;
            $display("FAIL invalid_code12: err=%0b act=%0b, required 1/1", entry_error, entry_active);
        end
        push(1'b1, 4'd2, 4'd3, 4'd0, 4'd0);
        key_in(4'd0);
        step();
        step();
    endtask

    task automatic test_timeout();
        bit early = 0;
        press(1'b1, 1'b0);
        key_in(4'd1);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            early |= (entry_timeout !== 1'b0) || (entry_active !== 1'b1);
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL timeout_early: timeout=%0b active=%0b before %0d idle cycles, required 0/1", entry_timeout, entry_active, TO);
        end
        step();
        tests++;
        if ({entry_timeout, entry_active, load_new_alarm, load_new_time, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min}
            !== {4'b1000, 16'h1000}) begin
            fails++;
            $display("FAIL timeout_pulse: to=%0b act=%0b la=%0b lt=%0b buf=%h, required 1/0/0/0 1000",
                     entry_timeout, entry_active, load_new_alarm, load_new_time, {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
        end
        step();
        tests++;
        if (entry_timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_width: to=%0b, required 0", entry_timeout);
        end
    endtask

    task automatic test_restart();
        press(1'b1, 1'b0);
        key_in(4'd1);
        key_in(4'd2);
        time_button = 1'b1;
        key_in(4'd3);
        time_button = 1'b0;
        tests++;
        if ({entry_active, entry_mode, entry_error, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} !== 19'h40000) begin
            fails++;
            $display("FAIL restart_clear: act=%0b mode=%0b err=%0b buf=%h, required 1/0/0 0000",
                     entry_active, entry_mode, entry_error, {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
        end
        key_in(4'd0);
        key_in(4'd8);
        key_in(4'd1);
        push(1'b0, 4'd0, 4'd8, 4'd1, 4'd5);
        key_in(4'd5);
        step();
        step();
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0);
        key_in(4'd1);
        key_in(4'd2);
        key_in(4'd3);
        reset = 1'b0;
        key_in(4'd4);
        tests++;
        if ({new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, load_new_alarm, load_new_time,
             entry_active, entry_mode, entry_error, entry_timeout} !== 22'd0) begin
            fails++;
            $display("FAIL reset_mid_entry: act=%0b buf=%h, required all 0", entry_active, {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
        end
        reset = 1'b1;
        // reset during COMMIT: no strobe must follow
        press(1'b1, 1'b0);
        key_in(4'd1);
        key_in(4'd2);
        key_in(4'd3);
        key_in(4'd4);
        reset = 1'b0;
        step();
        tests++;
        if ({load_new_alarm, load_new_time, entry_active, entry_error} !== 4'd0) begin
            fails++;
            $display("FAIL reset_in_commit: la=%0b lt=%0b act=%0b, required 0/0/0", load_new_alarm, load_new_time, entry_active);
        end
        reset = 1'b1;
        step();
        press(1'b1, 1'b0);
        key_in(4'd1);
        key_in(4'd2);
        key_in(4'd3);
        push(1'b1, 4'd1, 4'd2, 4'd3, 4'd0);
        key_in(4'd0);
        step();
        tests++;
        if ({load_new_alarm, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} !== {1'b1, 16'h1230}) begin
            fails++;
            $display("FAIL reload_1230: la=%0b buf=%h, required 1 1230", load_new_alarm, {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min});
        end
        step();
    endtask

    task automatic test_back_to_back();
        // A new entry started on the cycle right after a load strobe.
        press(1'b0, 1'b1);
        key_in(4'd1);
        key_in(4'd9);
        key_in(4'd5);
        push(1'b0, 4'd1, 4'd9, 4'd5, 4'd9);
        key_in(4'd9);
        step();
        press(1'b1, 1'b0);
        key_in(4'd0);
        key_in(4'd0);
        key_in(4'd0);
        push(1'b1, 4'd0, 4'd0, 4'd0, 4'd1);
        key_in(4'd1);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_alarm_0645();
        test_time_2359();
        test_invalid();
        test_timeout();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        repeat (3) step();
        tests++;
        if (sb.size() != 0 || loads_seen != loads_pushed) begin
            fails++;
            $display("FAIL sb_drain: seen=%0d pending=%0d, required seen=%0d pending=0", loads_seen, sb.size(), loads_pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
